// File: rtl/arch_pkg.sv
// Shared architecture definitions for the memory port arbiter:
// FSM state and owner encodings plus default bus widths.
package arch_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way picker producing a one-hot grant {data, fetch}.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise data has fixed priority.
module arb_pick
   import arch_pkg::*;
(
   input  logic       i_if_req,
   input  logic       i_d_req,
   input  owner_t     i_last_winner,
   output logic [1:0] o_gnt
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      o_gnt = 2'b00;
      if (i_if_req && i_d_req) begin
         // On contention the side that did not win last time goes first.
         if (i_last_winner == OWN_D) o_gnt = 2'b01;
         else                        o_gnt = 2'b10;
      end else begin
         o_gnt = {i_d_req, i_if_req};
      end
   end
`else
   logic w_unused_last;

   assign w_unused_last = i_last_winner;

   always_comb begin
      o_gnt = 2'b00;
      if (i_d_req)       o_gnt = 2'b10;
      else if (i_if_req) o_gnt = 2'b01;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and load/store; each access runs
// grant -> mem_en -> fixed-latency wait -> completion. Arbitration mode: MEM_ARB_RR_EN.
module mem_port_arbiter
   import arch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 3
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   owner_t              r_owner;
   owner_t              r_last;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;

   logic                r_if_gnt;
   logic                r_d_gnt;
   logic                r_if_valid;
   logic                r_d_valid;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_busy;

   logic [1:0]          w_pick;
   logic                w_grant_if;
   logic                w_grant_d;
   logic                w_issue;
   logic                w_done;

   arb_pick u_pick (
      .i_if_req      (if_req),
      .i_d_req       (d_req),
      .i_last_winner (r_last),
      .o_gnt         (w_pick)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick != 2'b00) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = WAIT;
         WAIT:    if (r_cnt == '0) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_grant_if = 1'b0;
      w_grant_d  = 1'b0;
      w_issue    = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         IDLE: begin
            w_grant_if = w_pick[0];
            w_grant_d  = w_pick[1];
         end
         ISSUE:   w_issue = 1'b1;
         DONE:    w_done  = 1'b1;
         default: ;
      endcase
   end

   // WAIT always spans MEM_LAT cycles so rdata lines up with DONE, including MEM_LAT=1.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_issue) begin
         r_cnt <= CNT_W'(MEM_LAT - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner     <= OWN_IF;
         r_last      <= OWN_D;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_gnt    <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_if_valid  <= 1'b0;
         r_d_valid   <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_if_gnt   <= w_grant_if;
         r_d_gnt    <= w_grant_d;
         r_mem_en   <= w_issue;
         r_if_valid <= w_done && (r_owner == OWN_IF);
         r_d_valid  <= w_done && (r_owner == OWN_D);
         r_busy     <= (r_state != IDLE);

         if (w_grant_if || w_grant_d) begin
            r_owner <= w_grant_d ? OWN_D : OWN_IF;
            r_we    <= w_grant_d & d_we;
            r_addr  <= w_grant_d ? d_addr : if_addr;
            r_wdata <= d_wdata;
         end

         if (w_issue) begin
            r_mem_we    <= (r_owner == OWN_D) & r_we;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
         end

         if (w_done) begin
            r_last <= r_owner;
            if (r_owner == OWN_IF)  r_if_rdata <= mem_rdata;
            else if (!r_we)         r_d_rdata  <= mem_rdata;
         end
      end
   end

   assign if_gnt    = r_if_gnt;
   assign d_gnt     = r_d_gnt;
   assign if_valid  = r_if_valid;
   assign d_valid   = r_d_valid;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-timeline model plus
// directed literal checks and randomized traffic with occasional resets.
module tb_mem_port_arbiter;

   localparam int ML = 2;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_gnt, if_valid, d_gnt, d_valid;
   logic [15:0] if_rdata, d_rdata;
   logic        mem_en, mem_we, busy;
   logic [15:0] mem_addr, mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(ML), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an access is a timeline counted from its grant cycle (t=0):
   // mem_en at t=1, completion at t=ML+2, where requests are sampled again.
   int          m_t = -1;
   bit          m_ready = 1'b0;
   bit          m_owner_d, m_we, m_last_d;
   logic [15:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

   task automatic model_step();
      bit pick_d;
      if (reset) begin
         m_t = -1; m_last_d = 1'b1; m_if_rdata = '0; m_d_rdata = '0; m_ready = 1'b1;
         return;
      end
      if (!m_ready) return;
      if (m_t < 0 || m_t == ML + 2) begin
         if (if_req || d_req) begin
            if (if_req && d_req) pick_d = RR ? !m_last_d : 1'b1;
            else                 pick_d = d_req;
            m_owner_d = pick_d;
            m_we      = pick_d & d_we;
            m_addr    = pick_d ? d_addr : if_addr;
            m_wdata   = d_wdata;
            m_t       = 0;
         end else begin
            m_t = -1;
         end
      end else begin
         m_t++;
         if (m_t == ML + 2) begin
            if (!m_owner_d)  m_if_rdata = mem_rdata;
            else if (!m_we)  m_d_rdata  = mem_rdata;
            m_last_d = m_owner_d;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_ready) begin
         chk("if_gnt",   if_gnt,   m_t == 0 && !m_owner_d);
         chk("d_gnt",    d_gnt,    m_t == 0 &&  m_owner_d);
         chk("mem_en",   mem_en,   m_t == 1);
         chk("if_valid", if_valid, m_t == ML + 2 && !m_owner_d);
         chk("d_valid",  d_valid,  m_t == ML + 2 &&  m_owner_d);
         chk("busy",     busy,     m_t >= 1);
         chk("if_rdata", if_rdata, m_if_rdata);
         chk("d_rdata",  d_rdata,  m_d_rdata);
         if (m_t == 1) begin
            chk("mem_we",   mem_we,   m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_en, t_en, t_v, ng;
      bit seq_d [4];
      int g_cyc [3];
      int n_v;
      bit seen;

      reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      tick(); tick();
      chk("rst_gnt",   {if_gnt, d_gnt}, 0);
      chk("rst_valid", {if_valid, d_valid}, 0);
      chk("rst_mem",   {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      chk("rst_busy",  busy, 0);

      // Single fetch: request in cycle 0
      reset = 1'b0; if_req = 1; if_addr = 16'h0010; mem_rdata = 16'hA5A5;
      tick(); chk("fetch_gnt_c1", if_gnt, 1); chk("fetch_busy_c1", busy, 0);
      tick(); chk("fetch_en_c2", mem_en, 1); chk("fetch_addr_c2", mem_addr, 16'h0010);
      chk("fetch_we_c2", mem_we, 0); chk("fetch_busy_c2", busy, 1);
      tick(); chk("fetch_busy_c3", busy, 1);
      tick(); chk("fetch_busy_c4", busy, 1);
      tick(); chk("fetch_valid_c5", if_valid, 1); chk("fetch_rdata_c5", if_rdata, 16'hA5A5);
      chk("fetch_busy_c5", busy, 1);
      if_req = 0;
      tick(); chk("fetch_idle_c6", busy, 0);

      // Store
      d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234; mem_rdata = 16'h5A5A;
      n_en = 0; t_en = -100; t_v = -1;
      for (int c = 0; c < 20 && t_v < 0; c++) begin
         tick();
         if (mem_en) begin
            n_en++; t_en = c;
            chk("store_we", mem_we, 1); chk("store_wdata", mem_wdata, 16'h1234);
            chk("store_addr", mem_addr, 16'h0200);
         end
         if (d_valid) begin t_v = c; d_req = 0; d_we = 0; end
      end
      chk("store_valid_seen", t_v >= 0, 1);
      chk("store_en_count", n_en, 1);
      chk("store_en_to_valid", t_v - t_en, 3);
      chk("store_d_rdata", d_rdata, 16'h0000);
      tick();

      // Simultaneous requests
      if_req = 1; d_req = 1; d_we = 0; if_addr = 16'h0100; d_addr = 16'h0300;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         tick();
         mem_rdata = 16'(c * 16'h0111);
         if (if_gnt || d_gnt) begin seq_d[ng] = d_gnt; ng++; end
      end
      if_req = 0; d_req = 0;
      chk("sim_grants", ng, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("sim_order%0d", i), seq_d[i], RR ? ((i % 2) == 1) : 1'b1);
      for (int c = 0; c < ML + 4; c++) tick();

      // Address change after grant
      d_req = 1; d_we = 0; d_addr = 16'h0040;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin tick(); seen = d_gnt; end
      chk("addr_gnt_seen", seen, 1);
      d_addr = 16'h0080;
      tick(); chk("addr_en", mem_en, 1); chk("addr_latched", mem_addr, 16'h0040);
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin tick(); seen = d_valid; end
      chk("addr_valid_seen", seen, 1);
      d_req = 0;
      tick();

      // Reset mid-access (in WAIT)
      if_req = 1; if_addr = 16'h0020;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin tick(); seen = if_gnt; end
      chk("rst_fetch_gnt", seen, 1);
      tick();
      reset = 1;
      tick();
      chk("rstmid_outs", {if_gnt, d_gnt, if_valid, d_valid, mem_en, busy}, 0);
      chk("rstmid_rdata", {if_rdata, d_rdata}, 0);
      reset = 0; d_req = 1; d_we = 0; d_addr = 16'h0044;
      tick();
      chk("rstmid_next_if", if_gnt, RR);
      chk("rstmid_next_d",  d_gnt, !RR);
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin tick(); seen = if_valid | d_valid; end
      chk("rstmid_done", seen, 1);
      if_req = 0; d_req = 0;
      tick();

      // Back-to-back fetches
      if_req = 1; if_addr = 16'h0030; ng = 0; n_v = 0;
      for (int c = 0; c < 40 && n_v < 3; c++) begin
         tick();
         if (if_gnt) begin if (ng < 3) g_cyc[ng] = c; ng++; end
         if (if_valid) n_v++;
         if (n_v == 3) if_req = 0;
      end
      chk("b2b_gnts", ng, 3);
      chk("b2b_valids", n_v, 3);
      chk("b2b_gap01", g_cyc[1] - g_cyc[0], 5);
      chk("b2b_gap12", g_cyc[2] - g_cyc[1], 5);
      tick(); tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         mem_rdata = 16'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         if (if_valid) if_req = 0;
         if (d_valid)  d_req  = 0;
         if (if_req && $urandom_range(0, 49) == 0) if_req = 0;
         if (d_req  && $urandom_range(0, 49) == 0) d_req  = 0;
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = 16'($urandom);
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
         end
         if ($urandom_range(0, 7) == 0) begin
            if_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
         end
         tick();
      end
      reset = 0; if_req = 0; d_req = 0;
      for (int c = 0; c < ML + 5; c++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
